// File: rtl/perf_counter_bank.sv
// Cycle/event counter bank with start/stop/clear control, self-halting cycle limit,
// snapshot shadow bank and a registered read port.
module perf_counter_bank #(
  parameter int unsigned NUM_CNT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CNT-1:0] event_i,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               snap,
  input  logic [CNT_W-1:0]   limit,
  input  logic [3:0]         rd_addr,
  output logic [CNT_W-1:0]   rd_data,
  output logic               running,
  output logic               done,
  output logic [NUM_CNT-1:0] ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q    [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d    [NUM_CNT];
  logic [CNT_W-1:0]   shadow_q [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic               count_en;
  logic               limit_hit;

  // A stop or clear in the same cycle suppresses the increment at that edge.
  assign count_en  = (state_q == StRun) && !clear && !stop;
  assign limit_hit = count_en && (limit != '0) && ((cnt_q[0] + One) == limit);

  always_comb begin
    ovf_d = ovf_q;
    for (int k = 0; k < NUM_CNT; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clear) begin
        cnt_d[k] = '0;
      end else if (count_en && ((k == 0) || event_i[k])) begin
        cnt_d[k] = cnt_q[k] + One;
        if (&cnt_q[k]) ovf_d[k] = 1'b1;
      end
    end
    if (clear) ovf_d = '0;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = (start && !stop) ? StRun : StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start && !stop) state_d = StRun;
        StRun: begin
          if (stop)           state_d = StIdle;
          else if (limit_hit) state_d = StDone;
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // Out-of-range addresses fall through to zero.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_addr == 4'(i)) rd_data_d = shadow_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      ovf_q     <= '0;
      rd_data_q <= '0;
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_q[k]    <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_q[k] <= cnt_d[k];
        if (snap) shadow_q[k] <= cnt_q[k];
      end
    end
  end

  assign rd_data = rd_data_q;
  assign running = (state_q == StRun);
  assign done    = (state_q == StDone);
  assign ovf     = ovf_q;

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised on-chip performance/cycle counter bank for the CPU top. It counts clock cycles and up to NUM_CNT hardware events between start/stop commands. It halts itself when a programmable cycle limit is reached, replacing the bench-side fixed run time and cycle printout. Counter values are captured into a shadow bank by a snapshot command and read out through a registered read port, so a bench or debug logic can inspect results without probing internal state.

## Interface

- NUM_CNT, default 4: number of counters, 2..16; counter 0 is the cycle counter.
- CNT_W, default 32: counter width, 8..64.

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- event_i  in  NUM_CNT  per-counter event strobe; bit 0 ignored.
- start  in  1  begin/resume counting (one-cycle pulse).
- stop  in  1  pause counting.
- clear  in  1  zero counters, ovf, done; return to IDLE.
- snap  in  1  copy live counters into shadow bank.
- limit  in  CNT_W  cycle limit for counter 0; 0 = no limit.
- rd_addr  in  4  shadow index to read.
- rd_data  out  CNT_W  registered shadow[rd_addr].
- running  out  1  state == RUN.
- done  out  1  state == DONE (limit reached).
- ovf  out  NUM_CNT  sticky per-counter wrap flag.

## Operation

- Reset (rst=0, async): state IDLE; all live counters, shadows, rd_data, ovf = 0; running = 0; done = 0.
- States:
  - IDLE: start → RUN.
  - RUN: stop → IDLE; limit hit → DONE.
  - DONE: only clear exits (→ IDLE); start/stop ignored.
- Command priority in the same cycle is clear > stop > start.
  - clear+start: counters zeroed, next state RUN.
  - stop+start in IDLE: stays IDLE.
- Counting happens only at edges where state == RUN.
  - Counter 0 increments by 1 every such edge.
  - Counter k ≥ 1 increments by 1 when event_i[k] = 1.
- Width rule: counters wrap modulo 2^CNT_W. A wrap (all-ones → 0) sets ovf[k], which is cleared only by clear or reset.
- Limit hit: counter 0 increments to a value equal to limit, with limit ≠ 0. At that same edge the state goes to DONE. Events sampled in that cycle are counted.
  - limit is compared live. Changing limit during RUN to a value at or below counter 0 gives no hit until a wrap.
- snap copies all live counters, as registered before the edge, into the shadow bank. snap+clear: the shadow gets the pre-clear values.
- Read port: rd_data is loaded every edge with shadow[rd_addr]. rd_addr ≥ NUM_CNT returns 0.

## Timing

- start sampled at edge N: running = 1 after edge N; first increment at edge N+1.
- Limit L from start at edge N: counter 0 = L, running = 0 and done = 1 all become visible after edge N+L.
- stop sampled at edge M: running = 0 after M; the increment at edge M does not occur.
- Read latency: 1 cycle from rd_addr to rd_data. A snap at edge S is visible on rd_data after edge S+1.
- Reset asserted mid-run clears everything immediately, without waiting for a clock edge. After release, the block sits in IDLE until a start.

## Test plan

- Reset mid-RUN with counters nonzero → immediately all outputs 0, running=0; after release, counters hold 0 for 5 idle cycles.
- limit=10, event_i[1]=1 constant, event_i[2] toggling starting at 1, start pulse → done after exactly 10 edges; snap+read gives cnt0=10, cnt1=10, cnt2=5; start while DONE ignored.
- CNT_W=8, limit=0, run 300 cycles then stop → cnt0=44, ovf[0]=1, other ovf bits 0 for counters with fewer than 256 events; clear → ovf=0.
- stop after 7 cycles, idle 5, start, 3 more cycles, stop → cnt0=10; running low during the gap.
- snap, then rd_addr=1,2,7 on consecutive cycles with NUM_CNT=4 → rd_data one cycle later: shadow1, shadow2, 0; live counters changing after snap do not alter rd_data.
- clear+start in the same cycle during DONE → counters 0, running=1 next cycle, counting resumes; stop+start in IDLE → stays IDLE.
